// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default bit timing.
package uart_pkg;

    // 100 MHz system clock, 115200 baud
    localparam int unsigned CLK_PER_BIT_DEFAULT = 868;

    // Serial payload width (8N1 framing)
    localparam int unsigned DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for a single asynchronous input, with a selectable reset value.
module uart_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Metastability filter: two back-to-back flops, both forced to RESET_VAL on reset
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: mid-bit sampling, LSB first, registered byte/strobe and framing-error pulse.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int unsigned CLK_PER_BIT = CLK_PER_BIT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx,
    output logic [DATA_W-1:0] data,
    output logic              ok,
    output logic              frame_err,
    output logic              busy
);

    localparam int unsigned HALF      = CLK_PER_BIT / 2;
    localparam int unsigned CNT_W     = $clog2(CLK_PER_BIT);
    localparam int unsigned IDX_W     = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);

    uart_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              ok_q, ok_d;
    logic              frame_err_q, frame_err_d;
    logic              busy_q, busy_d;
    logic [1:0]        prime_q, prime_d;
    logic              armed_q, armed_d;

    logic rx_s;
    logic half_tick_c;
    logic bit_tick_c;

    uart_sync #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d_i  (rx),
        .q_o  (rx_s)
    );

    assign half_tick_c = (cnt_q == HALF_LAST);
    assign bit_tick_c  = (cnt_q == BIT_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; starts are only accepted once the line has been seen idle after reset
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (armed_q && !rx_s) state_d = START;
            START:   if (half_tick_c) state_d = rx_s ? IDLE : DATA;
            DATA:    if (bit_tick_c && (bit_idx_q == IDX_LAST)) state_d = STOP;
            STOP:    if (bit_tick_c) state_d = rx_s ? IDLE : BREAK;
            BREAK:   if (rx_s) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        ok_d        = 1'b0;
        frame_err_d = 1'b0;
        // After reset the synchronizer holds its reset value for two cycles; ignore rx_s until it has refilled
        prime_d     = {prime_q[0], 1'b1};
        armed_d     = armed_q | (prime_q[1] & rx_s);
        case (state_q)
            IDLE: begin
                cnt_d     = '0;
                bit_idx_d = '0;
            end
            START: begin
                if (half_tick_c) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_tick_c) begin
                    shift_d   = {rx_s, shift_q[DATA_W-1:1]};
                    cnt_d     = '0;
                    bit_idx_d = bit_idx_q + IDX_W'(1);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (bit_tick_c) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        data_d = shift_q;
                        ok_d   = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            BREAK: begin
                cnt_d = '0;
            end
            default: begin
                cnt_d     = '0;
                bit_idx_d = '0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            ok_q        <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
            prime_q     <= '0;
            armed_q     <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            ok_q        <= ok_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
            prime_q     <= prime_d;
            armed_q     <= armed_d;
        end
    end

    assign data      = data_q;
    assign ok        = ok_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 16 clocks per bit.
module tb_uart_receiver;

    localparam int unsigned CPB  = 16;
    localparam int unsigned HALF = CPB / 2;
    localparam int          LAT  = 2 + HALF + 9 * CPB;   // 154
    localparam int          FRAME_LEN = 10 * CPB;        // start + 8 data + stop

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       rx    = 1'b1;
    logic [7:0] data;
    logic       ok;
    logic       frame_err;
    logic       busy;

    uart_receiver #(
        .CLK_PER_BIT(CPB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx       (rx),
        .data     (data),
        .ok       (ok),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    int         ok_cnt       = 0;
    int         ferr_cnt     = 0;
    int         both_cnt     = 0;
    int         busy_cnt     = 0;
    int         last_ok_edge = 0;
    logic [7:0] ok_data_q[$];
    int         ok_edge_q[$];

    // Event monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (ok) begin
            ok_cnt++;
            last_ok_edge = cyc;
            ok_data_q.push_back(data);
            ok_edge_q.push_back(cyc);
        end
        if (frame_err) ferr_cnt++;
        if (ok && frame_err) both_cnt++;
        if (busy) busy_cnt++;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Drive v for n clock edges; returns 1 time unit after the last edge
    task automatic hold(input logic v, input int n);
        rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One 8N1 frame; fall is the edge at which the first synchronizer flop captures the start bit
    task automatic send_frame(input logic [7:0] b, input logic stop, input int per, output int fall);
        fall = cyc + 1;
        hold(1'b0, per);
        for (int i = 0; i < 8; i++) hold(b[i], per);
        hold(stop, per);
    endtask

    typedef struct {
        logic [7:0] din;
        logic       stop;
        int         per;
        int         exp_ok;
        logic [7:0] exp_data;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int fall;
        int ok0, f0, n0;
        logic [7:0] exp_b2b[3];

        vecs[0] = '{8'hA5, 1'b1, 16, 1, 8'hA5, 0};
        vecs[1] = '{8'h00, 1'b1, 16, 1, 8'h00, 0};
        vecs[2] = '{8'hFF, 1'b1, 16, 1, 8'hFF, 0};
        vecs[3] = '{8'h3C, 1'b1, 16, 1, 8'h3C, 0};
        vecs[4] = '{8'h55, 1'b0, 16, 0, 8'h3C, 1};
        vecs[5] = '{8'h96, 1'b1, 17, 1, 8'h96, 0};
        vecs[6] = '{8'h01, 1'b1, 16, 1, 8'h01, 0};
        vecs[7] = '{8'h80, 1'b1, 16, 1, 8'h80, 0};

        // Reset state
        reset = 1'b1;
        rx    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_data", int'(data), 0);
        check("reset_ok", int'(ok), 0);
        check("reset_frame_err", int'(frame_err), 0);
        check("reset_busy", int'(busy), 0);
        reset = 1'b0;
        hold(1'b1, 4);

        // Table-driven single frames with idle gaps
        for (int v = 0; v < 8; v++) begin
            ok0 = ok_cnt;
            f0  = ferr_cnt;
            send_frame(vecs[v].din, vecs[v].stop, vecs[v].per, fall);
            hold(1'b1, 2 * CPB);
            check($sformatf("vec%0d_ok_count", v), ok_cnt - ok0, vecs[v].exp_ok);
            check($sformatf("vec%0d_ferr_count", v), ferr_cnt - f0, vecs[v].exp_ferr);
            check($sformatf("vec%0d_data", v), int'(data), int'(vecs[v].exp_data));
            check($sformatf("vec%0d_idle_busy", v), int'(busy), 0);
            if (vecs[v].exp_ok != 0)
                check($sformatf("vec%0d_latency", v), last_ok_edge - fall, LAT);
        end

        // Back-to-back frames, no idle between stop and next start
        exp_b2b[0] = 8'h00;
        exp_b2b[1] = 8'hFF;
        exp_b2b[2] = 8'h3C;
        n0 = ok_edge_q.size();
        f0 = ferr_cnt;
        for (int k = 0; k < 3; k++) send_frame(exp_b2b[k], 1'b1, CPB, fall);
        hold(1'b1, 2 * CPB);
        check("b2b_ok_count", ok_edge_q.size() - n0, 3);
        check("b2b_ferr_count", ferr_cnt - f0, 0);
        if (ok_edge_q.size() - n0 == 3) begin
            for (int k = 0; k < 3; k++)
                check($sformatf("b2b_data%0d", k), int'(ok_data_q[n0 + k]), int'(exp_b2b[k]));
            check("b2b_spacing01", ok_edge_q[n0 + 1] - ok_edge_q[n0], FRAME_LEN);
            check("b2b_spacing12", ok_edge_q[n0 + 2] - ok_edge_q[n0 + 1], FRAME_LEN);
        end

        // Start-bit glitch: 4 low cycles
        ok0 = ok_cnt;
        f0  = ferr_cnt;
        busy_cnt = 0;
        hold(1'b0, 4);
        hold(1'b1, 2 * CPB);
        check("glitch_ok_count", ok_cnt - ok0, 0);
        check("glitch_ferr_count", ferr_cnt - f0, 0);
        check("glitch_busy_max9", int'(busy_cnt <= 9), 1);
        check("glitch_busy_seen", int'(busy_cnt > 0), 1);
        check("glitch_data_held", int'(data), 8'h3C);

        // Framing error followed by a long break
        ok0 = ok_cnt;
        f0  = ferr_cnt;
        send_frame(8'h55, 1'b0, CPB, fall);
        hold(1'b0, 40);
        check("break_busy_low_line", int'(busy), 1);
        rx = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("break_busy_after_1", int'(busy), 1);
        @(posedge clk);
        #1;
        check("break_busy_after_2", int'(busy), 0);
        hold(1'b1, 3 * CPB);
        check("break_ferr_count", ferr_cnt - f0, 1);
        check("break_ok_count", ok_cnt - ok0, 0);
        check("break_data_held", int'(data), 8'h3C);
        check("break_idle_busy", int'(busy), 0);

        // Reset during data bit 4 of 0x81, then a clean 0x42
        ok0 = ok_cnt;
        f0  = ferr_cnt;
        hold(1'b0, CPB);                 // start
        hold(1'b1, CPB);                 // bit0
        hold(1'b0, 3 * CPB);             // bits1..3
        hold(1'b0, 8);                   // first half of bit4
        reset = 1'b1;
        hold(1'b0, 2);
        reset = 1'b0;
        hold(1'b0, 6);                   // rest of bit4
        hold(1'b0, 2 * CPB);             // bits5..6
        hold(1'b1, CPB);                 // bit7
        hold(1'b1, CPB);                 // stop
        hold(1'b1, 2 * CPB);
        check("abort_ok_count", ok_cnt - ok0, 0);
        check("abort_ferr_count", ferr_cnt - f0, 0);
        check("abort_data_reset", int'(data), 0);
        ok0 = ok_cnt;
        send_frame(8'h42, 1'b1, CPB, fall);
        hold(1'b1, 2 * CPB);
        check("post_reset_ok_count", ok_cnt - ok0, 1);
        check("post_reset_data", int'(data), 8'h42);
        check("post_reset_latency", last_ok_edge - fall, LAT);

        check("ok_ferr_overlap", both_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
